// File: rtl/reg_file_param_if.sv
// reg_file_param_if
//   Bundles the register-file bus between decode/writeback (master) and the
//   register file (slave).
//   WE3/A3/WD3 : write port (from writeback)
//   A1/A2      : read addresses (from decode)
//   RD1/RD2    : registered read data
//   READY      : post-reset clear finished, writes are accepted
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic              READY;

  modport master (
    output WE3, A3, WD3, A1, A2,
    input  RD1, RD2, READY
  );

  modport slave (
    input  WE3, A3, WD3, A1, A2,
    output RD1, RD2, READY
  );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param
//   1-write / 2-read register file with registered read ports, write-first
//   bypass, optional hardwired-zero entry 0 and a post-reset clear sequencer.
//   CLK  : clock, rising edge
//   RSTn : synchronous active-low reset
//   rf   : reg_file_param_if.slave (WE3/A3/WD3, A1/A2 -> RD1/RD2, READY)

// Per read port next-data select: range check, zero register, bypass.
module reg_file_param_rdport #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 1 << ADDR_W,
  parameter int ZERO_R0 = 1
) (
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] entry_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic in_range;
  logic is_zero;

  assign in_range = ({1'b0, raddr_i} < DEPTH_C);
  assign is_zero  = (ZERO_R0 != 0) && (raddr_i == '0);

  always_comb begin
    rdata_o = '0;
    // Out-of-range and hardwired-zero reads win over the bypass, so an
    // out-of-range write can never leak through to a read.
    if (in_range && !is_zero) begin
      if (we_i && (waddr_i == raddr_i)) rdata_o = wdata_i;
      else                              rdata_o = entry_i;
    end
  end
endmodule

module reg_file_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 1 << ADDR_W,
  parameter int ZERO_R0 = 1
) (
  input logic              CLK,
  input logic              RSTn,
  reg_file_param_if.slave  rf
);
  localparam int              NUM_RD   = 2;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e                          state_q, state_d;
  logic [ADDR_W-1:0]               clr_idx_q, clr_idx_d;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_q, rd_d;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_nxt;
  logic [NUM_RD-1:0][ADDR_W-1:0]   raddr;
  logic [NUM_RD-1:0][ADDR_W-1:0]   ridx;
  logic [NUM_RD-1:0][DATA_W-1:0]   entry;
  logic                            wr_en;
  logic                            wr_ok;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign raddr[0] = rf.A1;
  assign raddr[1] = rf.A2;

  // Write is legal only in range and, with a hardwired zero, not to entry 0.
  assign wr_ok = rf.WE3 && ({1'b0, rf.A3} < DEPTH_C) &&
                 !((ZERO_R0 != 0) && (rf.A3 == '0));

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      // Clamp the array index so out-of-range addresses never index past
      // the storage; the port logic zeroes such reads anyway.
      assign ridx[g]  = ({1'b0, raddr[g]} < DEPTH_C) ? raddr[g] : '0;
      assign entry[g] = mem_q[ridx[g]];

      reg_file_param_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .ZERO_R0(ZERO_R0)
      ) u_rdport (
        .raddr_i (raddr[g]),
        .we_i    (rf.WE3),
        .waddr_i (rf.A3),
        .wdata_i (rf.WD3),
        .entry_i (entry[g]),
        .rdata_o (rd_nxt[g])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rd_q      <= rd_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == S_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == LAST_IDX) state_d = S_RUN;
    end
  end

  // Outputs: read data is held at zero and writes are blocked while clearing.
  always_comb begin
    rd_d  = '0;
    wr_en = 1'b0;
    if (state_q == S_RUN) begin
      rd_d  = rd_nxt;
      wr_en = wr_ok;
    end
  end

  // Storage has no reset; the clear sequencer zeroes it after reset.
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      if (state_q == S_CLEAR) mem_q[clr_idx_q] <= '0;
      else if (wr_en)         mem_q[rf.A3]     <= rf.WD3;
    end
  end

  assign rf.RD1   = rd_q[0];
  assign rf.RD2   = rd_q[1];
  assign rf.READY = (state_q == S_RUN);
endmodule
